// File: rtl/mult_cell_arbiter_if.sv
// mult_cell_arbiter_if
//   Bundles every handshake and datapath signal between the multiplier
//   arbiter, its two requesters, the result consumer and the 16x16
//   three-partial-product multiplier cell.
//
//   Handshake rule (applies to req0, req1 and rsp alike): a transfer happens
//   on the rising clock edge where valid and ready are both 1. The source
//   holds valid and its payload steady until that edge; ready may depend
//   combinationally on valid, valid never depends on ready.
//
//   Signal groups:
//     req0_* / req1_*        requester N: valid, ready, operands a/b, hi select
//     rsp_*                  result: valid, ready, owner id, 32-bit word
//     busy                   arbiter has a transaction in flight
//     cell_src1/src2/en      operands and enable driven to the cell
//     cell_p1/p2/p3          partial products returned by the cell
//
//   Modports:
//     slave  - the arbiter's view
//     master - the environment's view (requesters, consumer, cell)
interface mult_cell_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_hi;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_hi;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        busy;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1;
    logic [31:0] cell_p2;
    logic [31:0] cell_p3;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_hi,
        input  req1_valid, req1_a, req1_b, req1_hi,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, busy,
        input  rsp_ready,
        output cell_src1, cell_src2, cell_en,
        input  cell_p1, cell_p2, cell_p3
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_hi,
        output req1_valid, req1_a, req1_b, req1_hi,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, busy,
        output rsp_ready,
        input  cell_src1, cell_src2, cell_en,
        output cell_p1, cell_p2, cell_p3
    );
endinterface

// File: rtl/mult_cell_arbiter.sv
// mult_cell_arbiter
//   Round-robin arbiter and sequencer that shares one 16x16 three-partial-
//   product multiplier cell between two requesters. One cell pass yields the
//   low 32 bits of the unsigned 32x32 product; an optional second pass on the
//   upper operand halves yields the high 32 bits.
//
//   Ports:
//     clk          rising-edge clock
//     reset        synchronous, active-high
//     bus          mult_cell_arbiter_if.slave (requests, response, cell)
//     o_dbg_state  current FSM state encoding, for observation only
//
//   Parameter:
//     HI_ENABLE    1: honour reqN_hi; 0: always return the low word
module mult_cell_arbiter #(
    parameter bit HI_ENABLE = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    mult_cell_arbiter_if.slave        bus,
    output logic [2:0]                o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE1 = 3'd1,
        S_CAP1   = 3'd2,
        S_ISSUE2 = 3'd3,
        S_CAP2   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_id;
    logic        r_hi;
    logic [15:0] r_a_hi;
    logic [15:0] r_b_hi;
    logic [16:0] r_mid_hi;
    logic        r_carry;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_result;
    logic        r_busy;
    logic        r_cell_en;
    logic [31:0] r_cell_src1;
    logic [31:0] r_cell_src2;

    logic        w_both;
    logic        w_any;
    logic        w_grant_id;
    logic        w_accept;
    logic [31:0] w_acc_a;
    logic [31:0] w_acc_b;
    logic        w_acc_hi;
    logic [32:0] w_mid;
    logic [32:0] w_lo33;
    logic [31:0] w_hi_word;

    // On a tie the grant goes to whoever did not win last time.
    assign w_both     = bus.req0_valid & bus.req1_valid;
    assign w_any      = bus.req0_valid | bus.req1_valid;
    assign w_grant_id = w_both ? ~r_last_grant : bus.req1_valid;
    // Ready is forced low during reset so nothing is acknowledged and dropped.
    assign w_accept   = (r_state == S_IDLE) & w_any & ~reset;

    assign bus.req0_ready = w_accept & ~w_grant_id;
    assign bus.req1_ready = w_accept &  w_grant_id;

    assign w_acc_a  = w_grant_id ? bus.req1_a : bus.req0_a;
    assign w_acc_b  = w_grant_id ? bus.req1_b : bus.req0_b;
    assign w_acc_hi = HI_ENABLE & (w_grant_id ? bus.req1_hi : bus.req0_hi);

    // Low word: p1 + ((p2 + p3) << 16). The 33-bit mid sum and the carry out
    // of the low-word add are both needed to finish the high word.
    assign w_mid     = {1'b0, bus.cell_p2} + {1'b0, bus.cell_p3};
    assign w_lo33    = {1'b0, bus.cell_p1} + {1'b0, w_mid[15:0], 16'h0000};
    // Second pass: p1 now holds a[31:16]*b[31:16]; p2/p3 are zero.
    assign w_hi_word = bus.cell_p1 + {15'h0000, r_mid_hi} + {31'h0, r_carry};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_hi         <= 1'b0;
            r_a_hi       <= 16'h0000;
            r_b_hi       <= 16'h0000;
            r_mid_hi     <= 17'h00000;
            r_carry      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 32'h0;
            r_busy       <= 1'b0;
            r_cell_en    <= 1'b0;
            r_cell_src1  <= 32'h0;
            r_cell_src2  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_hi         <= w_acc_hi;
                        r_a_hi       <= w_acc_a[31:16];
                        r_b_hi       <= w_acc_b[31:16];
                        // Operands and enable are registered so they appear
                        // exactly during the ISSUE1 cycle.
                        r_cell_src1  <= w_acc_a;
                        r_cell_src2  <= w_acc_b;
                        r_cell_en    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE1;
                    end
                end
                S_ISSUE1: begin
                    r_cell_en <= 1'b0;
                    r_state   <= S_CAP1;
                end
                S_CAP1: begin
                    r_mid_hi <= w_mid[32:16];
                    r_carry  <= w_lo33[32];
                    if (r_hi) begin
                        r_cell_src1 <= {16'h0000, r_a_hi};
                        r_cell_src2 <= {16'h0000, r_b_hi};
                        r_cell_en   <= 1'b1;
                        r_state     <= S_ISSUE2;
                    end else begin
                        r_rsp_result <= w_lo33[31:0];
                        r_rsp_id     <= r_id;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_ISSUE2: begin
                    r_cell_en <= 1'b0;
                    r_state   <= S_CAP2;
                end
                S_CAP2: begin
                    r_rsp_result <= w_hi_word;
                    r_rsp_id     <= r_id;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.busy       = r_busy;
    assign bus.cell_en    = r_cell_en;
    assign bus.cell_src1  = r_cell_src1;
    assign bus.cell_src2  = r_cell_src2;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_mult_cell_arbiter.sv
// tb_mult_cell_arbiter
//   Drives two arbiter instances (HI_ENABLE=1 and HI_ENABLE=0) with a
//   behavioural multiplier cell each. Expected {id, result} pairs are queued
//   at every accepted request and compared when the response is taken.
`timescale 1ns/1ps
module tb_mult_cell_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mult_cell_arbiter_if bus ();
    mult_cell_arbiter_if bus2 ();
    logic [2:0] dbg_state;
    logic [2:0] dbg_state2;

    mult_cell_arbiter #(.HI_ENABLE(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    mult_cell_arbiter #(.HI_ENABLE(1'b0)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus2),
        .o_dbg_state(dbg_state2)
    );

    // ---------------- behavioural multiplier cells ----------------
    always @(posedge clk) begin
        if (reset) begin
            bus.cell_p1 <= 32'h0;
            bus.cell_p2 <= 32'h0;
            bus.cell_p3 <= 32'h0;
        end else if (bus.cell_en) begin
            bus.cell_p1 <= bus.cell_src1[15:0]  * bus.cell_src2[15:0];
            bus.cell_p2 <= bus.cell_src1[15:0]  * bus.cell_src2[31:16];
            bus.cell_p3 <= bus.cell_src1[31:16] * bus.cell_src2[15:0];
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            bus2.cell_p1 <= 32'h0;
            bus2.cell_p2 <= 32'h0;
            bus2.cell_p3 <= 32'h0;
        end else if (bus2.cell_en) begin
            bus2.cell_p1 <= bus2.cell_src1[15:0]  * bus2.cell_src2[15:0];
            bus2.cell_p2 <= bus2.cell_src1[15:0]  * bus2.cell_src2[31:16];
            bus2.cell_p3 <= bus2.cell_src1[31:16] * bus2.cell_src2[15:0];
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic hi);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        return hi ? p[63:32] : p[31:0];
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [32:0] exp_q[$];
    int          grant_q[$];
    int          acc_cnt = 0;
    int          ready_cnt = 0;
    int          en_cnt = 0;
    int          en_cnt2 = 0;
    int          last_en_cyc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.req0_valid && bus.req0_ready) begin
                exp_q.push_back({1'b0, model(bus.req0_a, bus.req0_b, bus.req0_hi)});
                grant_q.push_back(0);
                acc_cnt++;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                exp_q.push_back({1'b1, model(bus.req1_a, bus.req1_b, bus.req1_hi)});
                grant_q.push_back(1);
                acc_cnt++;
            end
            if (bus.req0_ready) ready_cnt++;
            if (bus.req1_ready) ready_cnt++;
            if (bus.cell_en) begin
                en_cnt++;
                last_en_cyc = cyc;
            end
            if (bus2.cell_en) en_cnt2++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", bus.rsp_valid, 1'b0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check_eq("rsp_id", bus.rsp_id, e[32]);
                    check_eq("rsp_result", bus.rsp_result, e[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk_reset_outputs();
        check_eq("rst_req0_ready", bus.req0_ready, 1'b0);
        check_eq("rst_req1_ready", bus.req1_ready, 1'b0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check_eq("rst_rsp_id", bus.rsp_id, 1'b0);
        check_eq("rst_rsp_result", bus.rsp_result, 32'h0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_cell_en", bus.cell_en, 1'b0);
        check_eq("rst_cell_src1", bus.cell_src1, 32'h0);
        check_eq("rst_cell_src2", bus.cell_src2, 32'h0);
        check_eq("rst_state", dbg_state, 3'd0);
    endtask

    // Issues one request on requester n, waits for the accept, drops valid,
    // then waits for rsp_valid. Latency is counted from the accept cycle.
    task automatic send(input bit n, input logic [31:0] a, input logic [31:0] b, input bit hi,
                        output int lat, output int t0, output logic [31:0] res, output bit rid);
        bit ok;
        lat = 0;
        t0  = 0;
        res = 32'h0;
        rid = 1'b0;
        @(posedge clk);
        #1;
        if (n == 1'b0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_hi = hi; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_hi = hi; bus.req1_valid = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((n == 1'b0 && bus.req0_ready) || (n == 1'b1 && bus.req1_ready)) begin
                ok = 1'b1;
                t0 = cyc;
                break;
            end
        end
        check_eq("accept_wait", ok, 1'b1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ok  = 1'b1;
                lat = cyc - t0;
                res = bus.rsp_result;
                rid = bus.rsp_id;
                break;
            end
        end
        check_eq("rsp_wait", ok, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int          lat;
        int          t0;
        int          e0;
        int          a0;
        int          r0;
        int          seen;
        bit          ok;
        bit          rid;
        bit          rn;
        bit          rh;
        logic [31:0] res;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] exp_bp;

        reset = 1'b1;
        bus.req0_valid = 1'b1;  // must not see ready while reset is high
        bus.req0_a = 32'h1234_5678; bus.req0_b = 32'h9ABC_DEF0; bus.req0_hi = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_a = 32'h0; bus.req1_b = 32'h0; bus.req1_hi = 1'b0;
        bus.rsp_ready = 1'b1;
        bus2.req0_valid = 1'b0; bus2.req0_a = 32'h0; bus2.req0_b = 32'h0; bus2.req0_hi = 1'b0;
        bus2.req1_valid = 1'b0; bus2.req1_a = 32'h0; bus2.req1_b = 32'h0; bus2.req1_hi = 1'b0;
        bus2.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        bus.req0_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Low word, one cell pass
        e0 = en_cnt;
        send(1'b0, 32'h0001_0003, 32'h0002_0005, 1'b0, lat, t0, res, rid);
        check_eq("lo_result", res, 32'h000B_000F);
        check_eq("lo_id", rid, 1'b0);
        check_eq("lo_latency", lat, 3);
        check_eq("lo_en_pulses", en_cnt - e0, 1);
        check_eq("lo_en_cycle", last_en_cyc - t0, 1);

        // High word, two cell passes
        e0 = en_cnt;
        send(1'b0, 32'h0001_0003, 32'h0002_0005, 1'b1, lat, t0, res, rid);
        check_eq("hi_result", res, 32'h0000_0002);
        check_eq("hi_latency", lat, 5);
        check_eq("hi_en_pulses", en_cnt - e0, 2);
        send(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, t0, res, rid);
        check_eq("hi_ones", res, 32'hFFFF_FFFE);
        send(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, t0, res, rid);
        check_eq("lo_ones", res, 32'h0000_0001);
        drain();

        // Arbitration from reset with both requesters continuously valid
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        grant_q.delete();
        bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_hi = 1'($urandom_range(0, 1));
        bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_hi = 1'($urandom_range(0, 1));
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        a0 = acc_cnt;
        r0 = ready_cnt;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            if (acc_cnt - a0 >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check_eq("arb_accepts", ok, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (grant_q.size() > i) check_eq("arb_order", grant_q[i], i % 2);
            else check_eq("arb_order_missing", grant_q.size(), 4);
        end
        check_eq("arb_ready_pulses", ready_cnt - r0, 4);
        drain();

        // Back-pressure: hold rsp_ready low while a new request waits
        bus.rsp_ready = 1'b0;
        ra = $urandom;
        rb = $urandom;
        exp_bp = model(ra, rb, 1'b0);
        send(1'b1, ra, rb, 1'b0, lat, t0, res, rid);
        @(posedge clk);
        #1;
        bus.req0_a = 32'h0000_0007; bus.req0_b = 32'h0000_0009; bus.req0_hi = 1'b0;
        bus.req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_rsp_valid", bus.rsp_valid, 1'b1);
            check_eq("bp_rsp_result", bus.rsp_result, exp_bp);
            check_eq("bp_rsp_id", bus.rsp_id, 1'b1);
            check_eq("bp_req0_ready", bus.req0_ready, 1'b0);
            check_eq("bp_busy", bus.busy, 1'b1);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_no_accept_in_resp", bus.req0_ready, 1'b0);
        @(negedge clk);
        check_eq("bp_rsp_dropped", bus.rsp_valid, 1'b0);
        check_eq("bp_accept_in_idle", bus.req0_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        drain();

        // Reset during CAP2 drops the transaction
        @(posedge clk);
        #1;
        bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_hi = 1'b1;
        bus.req0_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("cap2_accept", ok, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_eq("cap2_state", dbg_state, 3'd4);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_reset_outputs();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check_eq("cap2_no_rsp", seen, 0);
        send(1'b1, 32'h0000_0010, 32'h0000_0010, 1'b0, lat, t0, res, rid);
        check_eq("post_rst_result", res, 32'h0000_0100);
        check_eq("post_rst_id", rid, 1'b1);
        check_eq("post_rst_latency", lat, 3);

        // Random traffic
        for (int k = 0; k < 6; k++) begin
            rn = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            send(rn, ra, rb, rh, lat, t0, res, rid);
            check_eq("rand_latency", lat, rh ? 5 : 3);
        end
        drain();

        // HI_ENABLE=0 instance ignores the hi select
        e0 = en_cnt2;
        @(posedge clk);
        #1;
        bus2.req0_a = 32'hFFFF_FFFF; bus2.req0_b = 32'hFFFF_FFFF; bus2.req0_hi = 1'b1;
        bus2.req0_valid = 1'b1;
        ok = 1'b0;
        t0 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus2.req0_ready) begin
                ok = 1'b1;
                t0 = cyc;
                break;
            end
        end
        check_eq("h0_accept", ok, 1'b1);
        @(posedge clk);
        #1;
        bus2.req0_valid = 1'b0;
        ok = 1'b0;
        lat = 0;
        res = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus2.rsp_valid) begin
                ok = 1'b1;
                lat = cyc - t0;
                res = bus2.rsp_result;
                break;
            end
        end
        check_eq("h0_rsp_wait", ok, 1'b1);
        check_eq("h0_result", res, 32'h0000_0001);
        check_eq("h0_latency", lat, 3);
        check_eq("h0_en_pulses", en_cnt2 - e0, 1);
        repeat (2) @(negedge clk);
        check_eq("h0_idle", dbg_state2, 3'd0);

        check_eq("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_cell_arbiter.md
# mult_cell_arbiter

Sequencing and arbitration controller for the CPU's three-partial-product 16x16 multiplier cell. It is placed between two multiply requesters (the CPU M-stage and a custom-instruction port) and the cell. It grants the cell to one requester at a time and drives the cell's operands and enable at the right cycles. From the p1/p2/p3 partial products it assembles the 32-bit low word of an unsigned 32x32 product, plus the high word on request using a second cell pass.

## Interface
Parameters:
- HI_ENABLE, default 1: 1 supports high-word requests; 0 ignores reqN_hi and always returns the low word.

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester N has a multiply pending; held with its operands until accepted
- req0_ready / req1_ready  out  1  accept strobe for requester N; the transfer occurs when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  32  unsigned operands
- req0_hi / req1_hi  in  1  1 returns product[63:32], 0 returns product[31:0]
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  1  index of the requester that owns the result
- rsp_result  out  32  result word
- busy  out  1  a transaction is in flight (state != IDLE)
- cell_src1, cell_src2  out  32  multiplier cell operands
- cell_en  out  1  cell enable; the cell registers its products on a clock edge where cell_en=1
- cell_p1, cell_p2, cell_p3  in  32  cell outputs: lo*lo, src1lo*src2hi, src1hi*src2lo. Valid the cycle after cell_en=1 and held while cell_en=0

## Operation
- States: IDLE, ISSUE1, CAP1, ISSUE2, CAP2, RESP.
- **IDLE:**
  - Round-robin arbitration. The grant goes to the requester other than last_grant when both are valid, otherwise to the sole valid one.
  - reqN_ready=1 combinationally for the granted requester only.
  - On accept, latch a, b, hi (forced to 0 if HI_ENABLE=0) and id, update last_grant, and go to ISSUE1.
  - last_grant resets to 1, so req0 wins the first tie.
- **ISSUE1:** cell_src1=a, cell_src2=b, cell_en=1. Go to CAP1.
- **CAP1:**
  - Compute mid = p2+p3 (33 bits).
  - Compute lo33 = p1 + {mid[15:0],16'h0} (33 bits). lo = lo33[31:0], c = lo33[32].
  - Store lo, mid[32:16] (17 bits) and c.
  - If hi=0, go to RESP with rsp_result=lo. Otherwise go to ISSUE2.
- **ISSUE2:** cell_src1={16'h0,a[31:16]}, cell_src2={16'h0,b[31:16]}, cell_en=1. Go to CAP2.
- **CAP2:** hi = p1 + mid[32:16] + c, mod 2^32. Go to RESP with rsp_result=hi.
- **RESP:**
  - rsp_valid=1; rsp_id and rsp_result are stable.
  - On rsp_ready=1, go to IDLE.
  - No requests are accepted in RESP.
- cell_en=0 in every state other than ISSUE1 and ISSUE2.
- cell_src1/cell_src2 hold their last driven values outside the ISSUE states.
- All arithmetic is unsigned and wraps modulo 2^32. No overflow flag.

## Timing
- **Reset values:** state IDLE, req0_ready=req1_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, cell_en=0, cell_src1=cell_src2=0, last_grant=1.
- **Reset mid-operation:** the next cycle matches the reset values and the in-flight transaction is dropped with no response. A requester that was already accepted is not re-acknowledged. reqN_ready is held at 0 while reset=1.
- **Latency:** accept at cycle T puts ISSUE1 at T+1, CAP1 at T+2, and rsp_valid=1 at T+3 for a low-word request, or T+5 for a high-word request.
- **Throughput:** with rsp_ready tied to 1, one low-word request is accepted every 4 cycles and one high-word request every 6 cycles.
- **Back-pressure:** rsp_valid stays high and rsp_id/rsp_result stay unchanged until rsp_ready=1. No accept occurs meanwhile and busy stays 1.
- **Requester handshake:** a requester that deasserts valid before ready is treated as never requesting. Its operands are sampled only on the accept edge.
- **Simultaneous events:** a request arriving in the same cycle as the RESP handshake is accepted no earlier than the next cycle, in IDLE.

## Test plan
- **Low word:** req0 with a=0x0001_0003, b=0x0002_0005, hi=0 -> rsp_result=0x000B_000F, rsp_id=0, rsp_valid at T+3; exactly one cell_en pulse, at T+1.
- **High word with carries:** same operands with hi=1 -> 0x0000_0002 at T+5. Then a=b=0xFFFF_FFFF: hi=1 -> 0xFFFF_FFFE, hi=0 -> 0x0000_0001.
- **Arbitration:** both valid out of reset -> req0 served first, then req1. With both continuously valid over 4 transactions -> grant order 0,1,0,1, exactly one ready pulse per accept, and rsp_id matching each owner.
- **Back-pressure:** rsp_ready low for 3 cycles in RESP -> rsp_result/rsp_id unchanged, req ready stays 0, rsp_valid drops one cycle after the rsp_ready=1 edge.
- **Reset in CAP2:** assert reset for 1 cycle during CAP2 -> all outputs at reset values the next cycle and no rsp_valid. Then req1 with 0x0000_0010 * 0x0000_0010, hi=0 -> 0x0000_0100, rsp_id=1.
- **HI_ENABLE=0:** req0 with hi=1 and a=b=0xFFFF_FFFF -> 0x0000_0001 at T+3 and exactly one cell_en pulse.
